// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer: steps NS/EW/walk phases off an external countdown timer,
// with pedestrian request latching and gate preemption (hold).
module traffic_phase_ctrl #(
  parameter int W          = 8,
  parameter int T_NS_GREEN = 10,
  parameter int T_EW_GREEN = 8,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 1,
  parameter int T_WALK     = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         timer_done,
  input  logic         ped_req,
  input  logic         hold,
  output logic         timer_start,
  output logic [W-1:0] timer_load,
  output logic         timer_enable,
  output logic [2:0]   ns_light,
  output logic [2:0]   ew_light,
  output logic         walk,
  output logic [2:0]   phase,
  output logic         ped_pending
);

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    NS_G = 3'd1,
    NS_Y = 3'd2,
    AR1  = 3'd3,
    WALK = 3'd4,
    EW_G = 3'd5,
    EW_Y = 3'd6,
    AR2  = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t         state_q, state_d;
  logic           done_eff;
  logic           entering_walk;
  logic           freeze_d;
  logic [W-1:0]   load_d;
  logic [2:0]     ns_d, ew_d;

  // A done pulse arriving while the timer is being reloaded belongs to the old phase.
  assign done_eff = timer_done && !timer_start;
  assign phase    = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = AR2;
      NS_G: if (hold || done_eff) state_d = NS_Y;
      NS_Y: if (done_eff) state_d = ped_pending ? WALK : AR1;
      AR1:  if (done_eff) state_d = EW_G;
      WALK: if (done_eff) state_d = EW_G;
      EW_G: if (hold || done_eff) state_d = EW_Y;
      EW_Y: if (done_eff) state_d = AR2;
      AR2:  if (done_eff) state_d = NS_G;
    endcase
  end

  always_comb begin
    load_d = '0;
    ns_d   = LAMP_R;
    ew_d   = LAMP_R;
    unique case (state_d)
      NS_G:     begin load_d = W'(T_NS_GREEN); ns_d = LAMP_G; end
      NS_Y:     begin load_d = W'(T_YELLOW);   ns_d = LAMP_Y; end
      EW_G:     begin load_d = W'(T_EW_GREEN); ew_d = LAMP_G; end
      EW_Y:     begin load_d = W'(T_YELLOW);   ew_d = LAMP_Y; end
      WALK:     load_d = W'(T_WALK);
      AR1, AR2: load_d = W'(T_ALLRED);
      BOOT:     load_d = '0;
    endcase
  end

  assign entering_walk = (state_d == WALK) && (state_q != WALK);
  assign freeze_d      = hold && (state_d inside {AR1, AR2, WALK});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      timer_start  <= 1'b0;
      timer_load   <= '0;
      timer_enable <= 1'b0;
      ns_light     <= LAMP_R;
      ew_light     <= LAMP_R;
      walk         <= 1'b0;
      ped_pending  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_start  <= (state_d != state_q);
      if (state_d != state_q) timer_load <= load_d;
      timer_enable <= !freeze_d;
      ns_light     <= ns_d;
      ew_light     <= ew_d;
      walk         <= (state_d == WALK);
      // A new press in the WALK-entry cycle survives the clear.
      ped_pending  <= ped_req || (ped_pending && !entering_walk);
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios plus random ped/hold
// traffic, checked cycle by cycle against a table-driven phase model.
module tb_traffic_phase_ctrl;
  localparam int W   = 8;
  localparam int TNS = 4;
  localparam int TEW = 3;
  localparam int TY  = 2;
  localparam int TAR = 1;
  localparam int TWK = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         timer_done;
  logic         ped_req = 1'b0;
  logic         hold = 1'b0;
  logic         timer_start;
  logic [W-1:0] timer_load;
  logic         timer_enable;
  logic [2:0]   ns_light, ew_light;
  logic         walk;
  logic [2:0]   phase;
  logic         ped_pending;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .W(W), .T_NS_GREEN(TNS), .T_EW_GREEN(TEW), .T_YELLOW(TY), .T_ALLRED(TAR), .T_WALK(TWK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .timer_done(timer_done), .ped_req(ped_req), .hold(hold),
    .timer_start(timer_start), .timer_load(timer_load), .timer_enable(timer_enable),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .phase(phase),
    .ped_pending(ped_pending)
  );

  // Environment: tick every 4 clocks and a countdown timer fed by the DUT.
  logic [1:0]   tcnt;
  logic         tick;
  logic [W-1:0] tleft;
  assign tick = (tcnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= 2'd0;
    else        tcnt <= tcnt + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tleft      <= '0;
      timer_done <= 1'b0;
    end else if (timer_start) begin
      tleft      <= timer_load;
      timer_done <= 1'b0;
    end else if (timer_enable && tick && tleft != '0) begin
      tleft      <= tleft - W'(1);
      timer_done <= (tleft == W'(1));
    end else begin
      timer_done <= 1'b0;
    end
  end

  int checks = 0;
  int failures = 0;

  // Reference model: phase number, latched request, and expected registered outputs.
  int m_phase, m_load;
  bit m_ped, m_start, m_en;
  int dur[8];
  int succ[8];
  int seq_ph[$];
  int seq_ld[$];

  function automatic logic [2:0] ns_exp(int p);
    return (p == 1) ? 3'b001 : (p == 2) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] ew_exp(int p);
    return (p == 5) ? 3'b001 : (p == 6) ? 3'b010 : 3'b100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_load = 0; m_ped = 0; m_start = 0; m_en = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".phase"}, 32'(phase), m_phase);
    chk({tag, ".start"}, 32'(timer_start), 32'(m_start));
    chk({tag, ".load"},  32'(timer_load), m_load);
    chk({tag, ".enable"}, 32'(timer_enable), 32'(m_en));
    chk({tag, ".ns"}, 32'(ns_light), 32'(ns_exp(m_phase)));
    chk({tag, ".ew"}, 32'(ew_light), 32'(ew_exp(m_phase)));
    chk({tag, ".walk"}, 32'(walk), 32'(m_phase == 4));
    chk({tag, ".ped"}, 32'(ped_pending), 32'(m_ped));
    chk({tag, ".safety"}, 32'(ns_light != 3'b100 && ew_light != 3'b100), 0);
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit p, input bit h);
    int nxt;
    ped_req = p;
    hold    = h;
    if (m_phase == 0)                               nxt = 7;
    else if ((m_phase == 1 || m_phase == 5) && h)   nxt = succ[m_phase];
    else if (timer_done === 1'b1 && !m_start)       nxt = (m_phase == 2 && m_ped) ? 4 : succ[m_phase];
    else                                            nxt = m_phase;
    m_start = (nxt != m_phase);
    if (m_start) m_load = dur[nxt];
    m_ped   = p || (m_ped && !(nxt == 4 && m_phase != 4));
    m_en    = !(h && (nxt == 3 || nxt == 4 || nxt == 7));
    m_phase = nxt;
    @(posedge clk);
    #1;
    if (timer_start === 1'b1) begin
      seq_ph.push_back(int'(phase));
      seq_ld.push_back(int'(timer_load));
    end
    check_model("cyc");
  endtask

  task automatic wait_phase(input int target, input bit h, input int budget);
    int n = 0;
    while (int'(phase) != target && n < budget) begin
      cyc(1'b0, h);
      n++;
    end
    chk("reach_phase", 32'(phase), target);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("rst_now");
    repeat (2) @(posedge clk);
    #1;
    check_model("rst_hold");
    rst_n = 1'b1;
    seq_ph.delete();
    seq_ld.delete();
  endtask

  initial begin
    int exp_ph[8];
    int exp_ld[8];
    int n;
    int starts;
    bit hr;
    dur  = '{0, TNS, TY, TAR, TWK, TEW, TY, TAR};
    succ = '{7, 2, 3, 5, 5, 6, 7, 1};
    exp_ph = '{7, 1, 2, 3, 5, 6, 7, 1};
    exp_ld = '{1, 4, 2, 1, 3, 2, 1, 4};

    @(negedge clk);
    do_reset();

    // Normal cycle with no requests.
    n = 0;
    while (seq_ph.size() < 8 && n < 400) begin cyc(0, 0); n++; end
    chk("seq_len", seq_ph.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < seq_ph.size()) begin
        chk("seq_phase", seq_ph[i], exp_ph[i]);
        chk("seq_load", seq_ld[i], exp_ld[i]);
      end
    end

    // Pedestrian request during NS_G, then another request inside WALK.
    cyc(1, 0);
    chk("ped_latched", 32'(ped_pending), 1);
    wait_phase(4, 0, 400);
    chk("walk_lamp", 32'(walk), 1);
    chk("walk_load", 32'(timer_load), TWK);
    cyc(0, 0);
    cyc(1, 0);
    wait_phase(5, 0, 400);
    chk("ped_kept", 32'(ped_pending), 1);
    wait_phase(4, 0, 400);

    // Preempt NS green, yellow completes under hold, AR1 freezes.
    wait_phase(1, 0, 400);
    repeat (3) cyc(0, 0);
    cyc(0, 1);
    chk("pre_phase", 32'(phase), 2);
    chk("pre_start", 32'(timer_start), 1);
    chk("pre_load", 32'(timer_load), TY);
    wait_phase(3, 1, 400);
    repeat (20) cyc(0, 1);
    chk("frz_phase", 32'(phase), 3);
    chk("frz_enable", 32'(timer_enable), 0);
    wait_phase(5, 0, 400);

    // Hold rising in EW_G together with timer_done.
    n = 0;
    while (!(phase == 3'd5 && timer_done === 1'b1) && n < 400) begin cyc(0, 0); n++; end
    chk("coin_reach", 32'(phase == 3'd5 && timer_done === 1'b1), 1);
    starts = 0;
    repeat (3) begin
      cyc(0, 1);
      if (timer_start === 1'b1) starts++;
    end
    chk("coin_phase", 32'(phase), 6);
    chk("coin_starts", starts, 1);
    cyc(0, 0);

    // Random pedestrian presses and hold bursts.
    hr = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) hr = !hr;
      cyc($urandom_range(0, 15) == 0, hr);
    end
    cyc(0, 0);

    // Reset in the middle of EW_Y.
    wait_phase(6, 0, 400);
    cyc(0, 0);
    #2;
    do_reset();
    n = 0;
    while (seq_ph.size() < 2 && n < 200) begin cyc(0, 0); n++; end
    chk("rst_seq_len", seq_ph.size(), 2);
    if (seq_ph.size() >= 2) begin
      chk("rst_seq0", seq_ph[0], 7);
      chk("rst_seq1", seq_ph[1], 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
